// File: rtl/tri_dispatch.sv
// tri_dispatch
// Initiator side of the hit-point stage's write interface. One ray at a time
// is popped from a first-word-fall-through ray FIFO. The block then reads
// triangle memory from address 0 to num_tris-1 and pushes one record per
// triangle into the hit-point stage, at up to one record per clock. Each
// record is {origin, dir, v0, v1, v2, normal, triangle_id}.
//
// Ports
//   clock, reset         system clock, synchronous active-high reset
//   ray_empty/ray_rd_en  ray FIFO handshake (data valid while ray_empty low)
//   ray_origin/ray_dir   head ray of the FIFO
//   num_tris             triangles to walk for the popped ray (sampled at pop)
//   tri_rd_en/tri_addr   triangle memory read port
//   tri_*_in             memory read data, valid the cycle after tri_rd_en
//   origin_out/dir_out   ray latched at pop, held for the whole ray
//   v0/v1/v2/tri_normal_out, triangle_id_out  record at the head of the buffer
//   out_wr_en/out_full   write handshake into the hit-point stage
//   busy                 a ray is in flight or records are still buffered
//   ray_done             one-cycle pulse once a ray's last record is written
module tri_dispatch #(
  parameter int D_BITS = 32,
  parameter int Q_BITS = 16,
  parameter int M_BITS = 32,
  parameter int A_BITS = 10
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   ray_empty,
  output logic                   ray_rd_en,
  input  logic [2:0][D_BITS-1:0] ray_origin,
  input  logic [2:0][D_BITS-1:0] ray_dir,
  input  logic [A_BITS:0]        num_tris,
  output logic                   tri_rd_en,
  output logic [A_BITS-1:0]      tri_addr,
  input  logic [2:0][D_BITS-1:0] tri_v0_in,
  input  logic [2:0][D_BITS-1:0] tri_v1_in,
  input  logic [2:0][D_BITS-1:0] tri_v2_in,
  input  logic [2:0][D_BITS-1:0] tri_normal_in,
  output logic [2:0][D_BITS-1:0] origin_out,
  output logic [2:0][D_BITS-1:0] dir_out,
  output logic [2:0][D_BITS-1:0] v0_out,
  output logic [2:0][D_BITS-1:0] v1_out,
  output logic [2:0][D_BITS-1:0] v2_out,
  output logic [2:0][D_BITS-1:0] tri_normal_out,
  output logic [M_BITS-1:0]      triangle_id_out,
  output logic                   out_wr_en,
  input  logic                   out_full,
  output logic                   busy,
  output logic                   ray_done
);

  // Coordinates (signed fixed point) are only passed through, so the fraction
  // width matters only as a sanity bound; the id must hold any address.
  if (Q_BITS >= D_BITS) begin : g_bad_q_bits
    $error("tri_dispatch: Q_BITS must be smaller than D_BITS");
  end
  if (M_BITS < A_BITS) begin : g_bad_m_bits
    $error("tri_dispatch: M_BITS must be at least A_BITS");
  end

  typedef logic [2:0][D_BITS-1:0] vec3_t;

  typedef struct packed {
    vec3_t             v0;
    vec3_t             v1;
    vec3_t             v2;
    vec3_t             nrm;
    logic [A_BITS-1:0] id;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_t;

  localparam logic [A_BITS:0] TRI_CAP  = {1'b1, {A_BITS{1'b0}}};
  localparam logic [A_BITS:0] ADDR_ONE = {{A_BITS{1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [A_BITS:0]   next_addr_q, next_addr_d;
  logic [A_BITS:0]   num_tris_q, num_tris_d;
  vec3_t             origin_q, origin_d;
  vec3_t             dir_q, dir_d;
  logic              inflight_q, inflight_d;
  logic [A_BITS-1:0] inflight_addr_q, inflight_addr_d;
  entry_t            buf_q [2];
  entry_t            buf_d [2];
  logic              head_q, head_d;
  logic              tail_q, tail_d;
  logic [1:0]        count_q, count_d;
  logic              done_q, done_d;

  logic              pop_ray;
  logic              issue_rd;
  logic              write_out;
  logic              load_buf;
  logic [2:0]        occupancy;
  logic [A_BITS:0]   tris_capped;
  entry_t            head_entry;

  // Two-entry output buffer. Memory data is valid exactly one cycle after a
  // read, so the in-flight flag doubles as the load strobe. Load and pop in
  // the same cycle leave the occupancy unchanged.
  always_comb begin
    buf_d     = buf_q;
    head_d    = head_q;
    tail_d    = tail_q;
    write_out = (count_q != 2'd0) && !out_full;
    load_buf  = inflight_q;
    occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, write_out};
    if (load_buf) begin
      buf_d[tail_q] = {tri_v0_in, tri_v1_in, tri_v2_in, tri_normal_in, inflight_addr_q};
      tail_d        = ~tail_q;
    end
    if (write_out) begin
      head_d = ~head_q;
    end
    count_d = count_q + {1'b0, load_buf} - {1'b0, write_out};
  end

  // Ray sequencing. A read is issued only when the records already committed
  // to the buffer (stored plus in flight, minus this cycle's write) leave a
  // free slot, so backpressure can never overflow the two entries.
  always_comb begin
    state_d         = state_q;
    next_addr_d     = next_addr_q;
    num_tris_d      = num_tris_q;
    origin_d        = origin_q;
    dir_d           = dir_q;
    done_d          = 1'b0;
    pop_ray         = 1'b0;
    issue_rd        = 1'b0;
    inflight_addr_d = inflight_addr_q;
    tris_capped     = (num_tris > TRI_CAP) ? TRI_CAP : num_tris;

    unique case (state_q)
      IDLE: begin
        // The cycle carrying ray_done must not also pop the next ray.
        pop_ray = !ray_empty && !done_q && !reset;
        if (pop_ray) begin
          origin_d    = ray_origin;
          dir_d       = ray_dir;
          num_tris_d  = tris_capped;
          next_addr_d = '0;
          if (tris_capped == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        issue_rd = (occupancy < 3'd2);
        if (issue_rd) begin
          next_addr_d     = next_addr_q + ADDR_ONE;
          inflight_addr_d = next_addr_q[A_BITS-1:0];
          if (next_addr_q == num_tris_q - ADDR_ONE) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Looking at the post-write occupancy lets ray_done land in the
        // cycle right after the final write.
        if ((count_d == 2'd0) && !inflight_q) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    inflight_d = issue_rd;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= IDLE;
      next_addr_q     <= '0;
      num_tris_q      <= '0;
      origin_q        <= '0;
      dir_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
      for (int i = 0; i < 2; i++) begin
        buf_q[i] <= '0;
      end
      head_q          <= 1'b0;
      tail_q          <= 1'b0;
      count_q         <= 2'd0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      next_addr_q     <= next_addr_d;
      num_tris_q      <= num_tris_d;
      origin_q        <= origin_d;
      dir_q           <= dir_d;
      inflight_q      <= inflight_d;
      inflight_addr_q <= inflight_addr_d;
      buf_q           <= buf_d;
      head_q          <= head_d;
      tail_q          <= tail_d;
      count_q         <= count_d;
      done_q          <= done_d;
    end
  end

  assign head_entry      = buf_q[head_q];
  assign ray_rd_en       = pop_ray;
  assign tri_rd_en       = issue_rd;
  assign tri_addr        = next_addr_q[A_BITS-1:0];
  assign origin_out      = origin_q;
  assign dir_out         = dir_q;
  assign v0_out          = head_entry.v0;
  assign v1_out          = head_entry.v1;
  assign v2_out          = head_entry.v2;
  assign tri_normal_out  = head_entry.nrm;
  assign triangle_id_out = M_BITS'(head_entry.id);
  assign out_wr_en       = write_out;
  assign busy            = (state_q != IDLE) || (count_q != 2'd0);
  assign ray_done        = done_q;

endmodule

// File: tb/tb_tri_dispatch.sv
// tb_tri_dispatch
// Self-checking bench for tri_dispatch. The bench models the ray FIFO and the
// triangle memory as its environment. Every ray expands into the record list
// the dispatcher must produce: ids 0..n-1, data taken from the memory
// contents function, and the ray's own origin and direction. What the DUT
// actually writes is logged and compared against that list.
module tb_tri_dispatch;

  localparam int D_BITS = 32;
  localparam int Q_BITS = 16;
  localparam int M_BITS = 32;
  localparam int A_BITS = 10;

  typedef logic [2:0][D_BITS-1:0] vec3_t;

  typedef struct {
    vec3_t org;
    vec3_t dir;
    int    n;
  } ray_t;

  typedef struct {
    int    id;
    vec3_t v0;
    vec3_t v1;
    vec3_t v2;
    vec3_t nrm;
    vec3_t org;
    vec3_t dir;
  } rec_t;

  logic              clock = 1'b0;
  logic              reset;
  logic              ray_empty;
  logic              ray_rd_en;
  vec3_t             ray_origin, ray_dir;
  logic [A_BITS:0]   num_tris;
  logic              tri_rd_en;
  logic [A_BITS-1:0] tri_addr;
  vec3_t             tri_v0_in, tri_v1_in, tri_v2_in, tri_normal_in;
  vec3_t             origin_out, dir_out, v0_out, v1_out, v2_out, tri_normal_out;
  logic [M_BITS-1:0] triangle_id_out;
  logic              out_wr_en;
  logic              out_full;
  logic              busy;
  logic              ray_done;

  tri_dispatch #(
    .D_BITS(D_BITS),
    .Q_BITS(Q_BITS),
    .M_BITS(M_BITS),
    .A_BITS(A_BITS)
  ) dut (
    .clock(clock),
    .reset(reset),
    .ray_empty(ray_empty),
    .ray_rd_en(ray_rd_en),
    .ray_origin(ray_origin),
    .ray_dir(ray_dir),
    .num_tris(num_tris),
    .tri_rd_en(tri_rd_en),
    .tri_addr(tri_addr),
    .tri_v0_in(tri_v0_in),
    .tri_v1_in(tri_v1_in),
    .tri_v2_in(tri_v2_in),
    .tri_normal_in(tri_normal_in),
    .origin_out(origin_out),
    .dir_out(dir_out),
    .v0_out(v0_out),
    .v1_out(v1_out),
    .v2_out(v2_out),
    .tri_normal_out(tri_normal_out),
    .triangle_id_out(triangle_id_out),
    .out_wr_en(out_wr_en),
    .out_full(out_full),
    .busy(busy),
    .ray_done(ray_done)
  );

  always #5 clock = ~clock;

  ray_t  ray_fifo[$];
  rec_t  obs[$];
  rec_t  exp_q[$];
  int    read_addrs[$];
  int    pop_cycles[$];
  int    done_cycles[$];
  int    write_cycles[$];
  int    read_cycles[$];
  vec3_t org_log[$];
  int    cyc;
  int    max_outstanding;
  int    wr_while_full;
  int    busy_cycles;
  int    done_pop_clash;
  int    full_mode;
  int    full_lo, full_hi, full_pct;
  int    checks = 0;
  int    errors = 0;

  logic              s_ray_rd_en, s_tri_rd_en, s_out_wr_en, s_busy, s_done, s_data_nz;
  logic [A_BITS-1:0] s_tri_addr;
  logic [M_BITS-1:0] s_id;

  // Contents of triangle memory: unique for every address, field and lane.
  function automatic vec3_t memf(int addr, int field);
    vec3_t v;
    for (int k = 0; k < 3; k++) begin
      v[k] = 32'h5A00_0000 + 32'(addr) * 32'h10 + 32'(field) * 32'd4 + 32'(k);
    end
    return v;
  endfunction

  function automatic vec3_t rand_vec();
    vec3_t v;
    for (int k = 0; k < 3; k++) begin
      v[k] = $urandom;
    end
    return v;
  endfunction

  function automatic void add_expected(ray_t r);
    rec_t e;
    for (int i = 0; i < r.n; i++) begin
      e.id  = i;
      e.v0  = memf(i, 0);
      e.v1  = memf(i, 1);
      e.v2  = memf(i, 2);
      e.nrm = memf(i, 3);
      e.org = r.org;
      e.dir = r.dir;
      exp_q.push_back(e);
    end
  endfunction

  function automatic bit same_rec(rec_t a, rec_t b);
    return (a.id == b.id) && (a.v0 === b.v0) && (a.v1 === b.v1) && (a.v2 === b.v2) &&
           (a.nrm === b.nrm) && (a.org === b.org) && (a.dir === b.dir);
  endfunction

  // Index of the first record that differs from the expected list, or -1.
  function automatic int first_diff();
    int n;
    n = (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      if (!same_rec(obs[i], exp_q[i])) return i;
    end
    return -1;
  endfunction

  task automatic drive_head();
    ray_empty = (ray_fifo.size() == 0);
    if (ray_fifo.size() != 0) begin
      ray_origin = ray_fifo[0].org;
      ray_dir    = ray_fifo[0].dir;
      num_tris   = (A_BITS+1)'(ray_fifo[0].n);
    end else begin
      ray_origin = rand_vec();
      ray_dir    = rand_vec();
      num_tris   = (A_BITS+1)'($urandom);
    end
  endtask

  task automatic push_ray(vec3_t o, vec3_t d, int n);
    ray_t r;
    r.org = o;
    r.dir = d;
    r.n   = n;
    ray_fifo.push_back(r);
    add_expected(r);
    drive_head();
  endtask

  task automatic clear_logs();
    obs.delete();
    exp_q.delete();
    read_addrs.delete();
    pop_cycles.delete();
    done_cycles.delete();
    write_cycles.delete();
    read_cycles.delete();
    org_log.delete();
    cyc             = 0;
    max_outstanding = 0;
    wr_while_full   = 0;
    busy_cycles     = 0;
    done_pop_clash  = 0;
  endtask

  // One clock: sample outputs at the falling edge and log them, then, just
  // after the rising edge, update the FIFO and memory models and out_full.
  task automatic step();
    logic rd;
    logic pop;
    int   addr;
    int   outstanding;
    rec_t r;
    @(negedge clock);
    s_ray_rd_en = ray_rd_en;
    s_tri_rd_en = tri_rd_en;
    s_out_wr_en = out_wr_en;
    s_busy      = busy;
    s_done      = ray_done;
    s_tri_addr  = tri_addr;
    s_id        = triangle_id_out;
    s_data_nz   = |{origin_out, dir_out, v0_out, v1_out, v2_out, tri_normal_out};
    org_log.push_back(origin_out);
    if (out_wr_en) begin
      r.id  = int'(triangle_id_out);
      r.v0  = v0_out;
      r.v1  = v1_out;
      r.v2  = v2_out;
      r.nrm = tri_normal_out;
      r.org = origin_out;
      r.dir = dir_out;
      obs.push_back(r);
      write_cycles.push_back(cyc);
      if (out_full) wr_while_full++;
    end
    if (tri_rd_en) begin
      read_addrs.push_back(int'(tri_addr));
      read_cycles.push_back(cyc);
    end
    if (ray_rd_en) pop_cycles.push_back(cyc);
    if (ray_done) done_cycles.push_back(cyc);
    if (ray_done && ray_rd_en) done_pop_clash++;
    if (busy) busy_cycles++;
    outstanding = read_addrs.size() - obs.size();
    if (outstanding > max_outstanding) max_outstanding = outstanding;
    rd   = tri_rd_en;
    pop  = ray_rd_en;
    addr = int'(tri_addr);

    @(posedge clock);
    #1;
    if (pop && ray_fifo.size() != 0) ray_fifo.delete(0);
    drive_head();
    if (rd) begin
      tri_v0_in     = memf(addr, 0);
      tri_v1_in     = memf(addr, 1);
      tri_v2_in     = memf(addr, 2);
      tri_normal_in = memf(addr, 3);
    end else begin
      tri_v0_in     = rand_vec();
      tri_v1_in     = rand_vec();
      tri_v2_in     = rand_vec();
      tri_normal_in = rand_vec();
    end
    cyc++;
    case (full_mode)
      1: out_full = (pop_cycles.size() != 0) && (cyc >= pop_cycles[$] + full_lo) &&
                    (cyc <= pop_cycles[$] + full_hi);
      2: out_full = ($urandom_range(99) < full_pct);
      default: out_full = 1'b0;
    endcase
  endtask

  task automatic wait_dones(int target, int budget, output bit timed_out);
    int n;
    n = 0;
    timed_out = 1'b0;
    while (done_cycles.size() < target) begin
      if (n >= budget) begin
        timed_out = 1'b1;
        break;
      end
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    ray_empty = 1'b1;
    out_full  = 1'b0;
    full_mode = 0;
    step();
    step();
    checks++;
    if ({s_ray_rd_en, s_tri_rd_en, s_out_wr_en, s_busy, s_done} !== 5'b00000) begin
      errors++;
      $display("[TB] FAIL reset_strobes: got %b expected 00000",
               {s_ray_rd_en, s_tri_rd_en, s_out_wr_en, s_busy, s_done});
    end
    checks++;
    if (s_tri_addr !== '0) begin
      errors++;
      $display("[TB] FAIL reset_tri_addr: got %0d expected 0", s_tri_addr);
    end
    checks++;
    if (s_id !== '0 || s_data_nz !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_data: got id %0d data_nonzero %b expected 0 0", s_id, s_data_nz);
    end
    reset = 1'b0;
    step();
    checks++;
    if ({s_ray_rd_en, s_tri_rd_en, s_out_wr_en, s_busy, s_done} !== 5'b00000) begin
      errors++;
      $display("[TB] FAIL idle_after_reset: got %b expected 00000",
               {s_ray_rd_en, s_tri_rd_en, s_out_wr_en, s_busy, s_done});
    end
  endtask

  task automatic test_single_ray();
    bit    to;
    int    p, d, fw, bad;
    vec3_t o;
    clear_logs();
    full_mode = 0;
    out_full  = 1'b0;
    o[0] = 32'h0001_0000;
    o[1] = 32'h0002_0000;
    o[2] = 32'h0003_0000;
    push_ray(o, rand_vec(), 3);
    wait_dones(1, 60, to);
    repeat (4) step();
    p  = (pop_cycles.size() != 0) ? pop_cycles[0] : -100;
    d  = (done_cycles.size() != 0) ? done_cycles[0] : -100;
    fw = (write_cycles.size() != 0) ? write_cycles[0] : -100;
    checks++;
    if (to || pop_cycles.size() != 1) begin
      errors++;
      $display("[TB] FAIL single_pop: got timeout %0d pops %0d expected 0 1", to, pop_cycles.size());
    end
    checks++;
    if (read_cycles.size() == 0 || read_cycles[0] != p + 1) begin
      errors++;
      $display("[TB] FAIL single_first_read: got reads %0d expected first read at pop+1", read_cycles.size());
    end
    checks++;
    if (fw != p + 3) begin
      errors++;
      $display("[TB] FAIL single_first_write: got cycle %0d expected %0d", fw, p + 3);
    end
    bad = 0;
    for (int i = 0; i < write_cycles.size(); i++) begin
      if (write_cycles[i] != p + 3 + i) bad++;
    end
    checks++;
    if (write_cycles.size() != 3 || bad != 0) begin
      errors++;
      $display("[TB] FAIL single_write_train: got %0d writes %0d gaps expected 3 0", write_cycles.size(), bad);
    end
    checks++;
    if (obs.size() != exp_q.size() || first_diff() != -1) begin
      errors++;
      $display("[TB] FAIL single_records: got %0d records first diff %0d expected %0d records diff -1",
               obs.size(), first_diff(), exp_q.size());
    end
    checks++;
    if (done_cycles.size() != 1 || d <= write_cycles[$]) begin
      errors++;
      $display("[TB] FAIL single_done: got %0d pulses at %0d expected 1 after cycle %0d",
               done_cycles.size(), d, write_cycles[$]);
    end
    bad = 0;
    for (int c = p + 1; c <= d && c < org_log.size() && c >= 0; c++) begin
      if (org_log[c] !== o) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL single_origin_hold: got %0d cycles differing expected 0", bad);
    end
  endtask

  task automatic test_backpressure();
    bit to;
    int p, bad, stalled_reads;
    clear_logs();
    full_mode = 1;
    full_lo   = 4;
    full_hi   = 9;
    out_full  = 1'b0;
    push_ray(rand_vec(), rand_vec(), 8);
    wait_dones(1, 120, to);
    repeat (3) step();
    full_mode = 0;
    p = (pop_cycles.size() != 0) ? pop_cycles[0] : -100;
    checks++;
    if (to || obs.size() != 8) begin
      errors++;
      $display("[TB] FAIL bp_write_count: got timeout %0d writes %0d expected 0 8", to, obs.size());
    end
    checks++;
    if (first_diff() != -1) begin
      errors++;
      $display("[TB] FAIL bp_records: got first diff at %0d expected -1", first_diff());
    end
    checks++;
    if (wr_while_full != 0) begin
      errors++;
      $display("[TB] FAIL bp_write_when_full: got %0d expected 0", wr_while_full);
    end
    checks++;
    if (max_outstanding > 2) begin
      errors++;
      $display("[TB] FAIL bp_outstanding: got %0d expected at most 2", max_outstanding);
    end
    stalled_reads = 0;
    foreach (read_cycles[i]) begin
      if (read_cycles[i] >= p + 5 && read_cycles[i] <= p + 9) stalled_reads++;
    end
    checks++;
    if (stalled_reads != 0) begin
      errors++;
      $display("[TB] FAIL bp_read_stall: got %0d reads while full expected 0", stalled_reads);
    end
    bad = 0;
    foreach (read_addrs[i]) begin
      if (read_addrs[i] != i) bad++;
    end
    checks++;
    if (read_addrs.size() != 8 || bad != 0) begin
      errors++;
      $display("[TB] FAIL bp_read_addrs: got %0d reads %0d out of order expected 8 0", read_addrs.size(), bad);
    end
  endtask

  task automatic test_zero_tris();
    bit to;
    int p;
    clear_logs();
    full_mode = 0;
    out_full  = 1'b0;
    push_ray(rand_vec(), rand_vec(), 0);
    wait_dones(1, 20, to);
    repeat (3) step();
    p = (pop_cycles.size() != 0) ? pop_cycles[0] : -100;
    checks++;
    if (to || pop_cycles.size() != 1 || done_cycles.size() != 1) begin
      errors++;
      $display("[TB] FAIL zero_pop_done: got timeout %0d pops %0d dones %0d expected 0 1 1",
               to, pop_cycles.size(), done_cycles.size());
    end
    checks++;
    if (done_cycles.size() == 0 || done_cycles[0] != p + 1) begin
      errors++;
      $display("[TB] FAIL zero_done_latency: got %0d dones expected pulse at pop+1", done_cycles.size());
    end
    checks++;
    if (read_addrs.size() != 0 || obs.size() != 0 || busy_cycles != 0) begin
      errors++;
      $display("[TB] FAIL zero_activity: got reads %0d writes %0d busy %0d expected 0 0 0",
               read_addrs.size(), obs.size(), busy_cycles);
    end
  endtask

  task automatic test_two_rays();
    bit    to;
    int    p2;
    vec3_t oa, ob;
    clear_logs();
    full_mode = 0;
    out_full  = 1'b0;
    oa = rand_vec();
    ob = ~oa;
    push_ray(oa, rand_vec(), 2);
    push_ray(ob, rand_vec(), 2);
    wait_dones(2, 80, to);
    repeat (3) step();
    checks++;
    if (to || pop_cycles.size() != 2 || done_cycles.size() != 2) begin
      errors++;
      $display("[TB] FAIL two_counts: got timeout %0d pops %0d dones %0d expected 0 2 2",
               to, pop_cycles.size(), done_cycles.size());
    end
    p2 = (pop_cycles.size() > 1) ? pop_cycles[1] : 0;
    checks++;
    if (done_cycles.size() == 0 || p2 <= done_cycles[0] || done_pop_clash != 0) begin
      errors++;
      $display("[TB] FAIL two_pop_order: got second pop %0d clashes %0d expected after first done, 0",
               p2, done_pop_clash);
    end
    checks++;
    if (obs.size() != 4 || first_diff() != -1) begin
      errors++;
      $display("[TB] FAIL two_records: got %0d records first diff %0d expected 4 -1", obs.size(), first_diff());
    end
    checks++;
    if (p2 + 1 >= org_log.size() || org_log[p2] !== oa || org_log[p2 + 1] !== ob) begin
      errors++;
      $display("[TB] FAIL two_origin_switch: got switch not at second pop %0d expected old then new", p2);
    end
  endtask

  task automatic test_reset_mid_ray();
    bit    to;
    int    n;
    vec3_t o;
    clear_logs();
    full_mode = 0;
    out_full  = 1'b0;
    push_ray(rand_vec(), rand_vec(), 5);
    n = 0;
    to = 1'b0;
    do begin
      step();
      n++;
      if (n > 10) to = 1'b1;
    end while (!s_tri_rd_en && !to);
    checks++;
    if (to) begin
      errors++;
      $display("[TB] FAIL mid_first_read: got no read in 10 cycles expected one");
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    checks++;
    if ({s_ray_rd_en, s_tri_rd_en, s_out_wr_en, s_busy, s_done} !== 5'b00000 ||
        s_tri_addr !== '0 || s_id !== '0 || s_data_nz !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_reset_outputs: got strobes %b addr %0d id %0d data_nonzero %b expected all 0",
               {s_ray_rd_en, s_tri_rd_en, s_out_wr_en, s_busy, s_done}, s_tri_addr, s_id, s_data_nz);
    end
    repeat (4) step();
    checks++;
    if (obs.size() != 0) begin
      errors++;
      $display("[TB] FAIL mid_aborted_writes: got %0d writes expected 0", obs.size());
    end
    clear_logs();
    o = rand_vec();
    push_ray(o, rand_vec(), 2);
    wait_dones(1, 40, to);
    repeat (2) step();
    checks++;
    if (to || obs.size() != 2 || first_diff() != -1) begin
      errors++;
      $display("[TB] FAIL mid_restart: got timeout %0d records %0d first diff %0d expected 0 2 -1",
               to, obs.size(), first_diff());
    end
  endtask

  task automatic test_random_rays();
    bit to;
    clear_logs();
    full_mode = 2;
    full_pct  = 40;
    for (int r = 0; r < 5; r++) begin
      push_ray(rand_vec(), rand_vec(), $urandom_range(0, 6));
    end
    wait_dones(5, 600, to);
    repeat (3) step();
    full_mode = 0;
    checks++;
    if (to || done_cycles.size() != 5 || done_pop_clash != 0) begin
      errors++;
      $display("[TB] FAIL rand_dones: got timeout %0d dones %0d clashes %0d expected 0 5 0",
               to, done_cycles.size(), done_pop_clash);
    end
    checks++;
    if (obs.size() != exp_q.size() || first_diff() != -1) begin
      errors++;
      $display("[TB] FAIL rand_records: got %0d records first diff %0d expected %0d -1",
               obs.size(), first_diff(), exp_q.size());
    end
    checks++;
    if (wr_while_full != 0 || max_outstanding > 2) begin
      errors++;
      $display("[TB] FAIL rand_flow: got writes when full %0d outstanding %0d expected 0 at most 2",
               wr_while_full, max_outstanding);
    end
  endtask

  task automatic test_full_range();
    bit to;
    int bad;
    clear_logs();
    full_mode = 2;
    full_pct  = 50;
    push_ray(rand_vec(), rand_vec(), 1024);
    wait_dones(1, 6000, to);
    repeat (3) step();
    full_mode = 0;
    checks++;
    if (to || obs.size() != 1024 || done_cycles.size() != 1) begin
      errors++;
      $display("[TB] FAIL full_counts: got timeout %0d writes %0d dones %0d expected 0 1024 1",
               to, obs.size(), done_cycles.size());
    end
    checks++;
    if (first_diff() != -1) begin
      errors++;
      $display("[TB] FAIL full_records: got first diff at %0d expected -1", first_diff());
    end
    checks++;
    if (obs.size() == 0 || obs[$].id != 1023) begin
      errors++;
      $display("[TB] FAIL full_last_id: got %0d expected 1023", (obs.size() != 0) ? obs[$].id : -1);
    end
    bad = 0;
    foreach (read_addrs[i]) begin
      if (read_addrs[i] != i) bad++;
    end
    checks++;
    if (read_addrs.size() != 1024 || bad != 0) begin
      errors++;
      $display("[TB] FAIL full_addrs: got %0d reads %0d out of sequence expected 1024 0", read_addrs.size(), bad);
    end
    checks++;
    if (wr_while_full != 0 || max_outstanding > 2) begin
      errors++;
      $display("[TB] FAIL full_flow: got writes when full %0d outstanding %0d expected 0 at most 2",
               wr_while_full, max_outstanding);
    end
  endtask

  initial begin
    reset         = 1'b1;
    ray_empty     = 1'b1;
    out_full      = 1'b0;
    ray_origin    = '0;
    ray_dir       = '0;
    num_tris      = '0;
    tri_v0_in     = '0;
    tri_v1_in     = '0;
    tri_v2_in     = '0;
    tri_normal_in = '0;
    full_mode     = 0;
    full_lo       = 0;
    full_hi       = 0;
    full_pct      = 0;
    clear_logs();

    test_reset();
    test_single_ray();
    test_backpressure();
    test_zero_tris();
    test_two_rays();
    test_reset_mid_ray();
    test_random_rays();
    test_full_range();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
